// File: rtl/vc_writeback_buffer_pkg.sv
// Shared line/address types and the drain state encoding for the victim-cache
// write-back path.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;

    typedef enum logic {
        WB_IDLE,
        WB_WRITE
    } wb_state_t;

endpackage

// File: rtl/vc_writeback_buffer_match.sv
// Parallel address compare across all buffer entries, qualified by valid, with a
// youngest-first select (relative to tail) of the matching index.
module wb_match
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  lc3b_line_addr             addr,
    input  lc3b_line_addr [DEPTH-1:0] entry_addr,
    input  logic [DEPTH-1:0]          valid,
    input  logic [PW-1:0]             tail,
    output logic [DEPTH-1:0]          hit_vec,
    output logic [PW-1:0]             idx
);

    always_comb begin
        hit_vec = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            hit_vec[k] = valid[k] && (entry_addr[k] == addr);
        end
    end

    // Walk from the oldest slot (tail) towards tail-1; the last hit seen is the youngest.
    always_comb begin
        idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (hit_vec[PW'(tail + PW'(k))]) begin
                idx = PW'(tail + PW'(k));
            end
        end
    end

endmodule

// File: rtl/vc_writeback_buffer.sv
// FIFO write-back buffer: captures evicted dirty lines, coalesces repeats, drains
// them over the pmem write handshake and forwards queued lines to the L2 miss path.
module vc_writeback_buffer
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wb_valid,
    input  logic [11:0]                  wb_address,
    input  logic [127:0]                 wb_data,
    output logic                         wb_ready,
    output logic                         pmem_write,
    output logic [15:0]                  pmem_address,
    output logic [127:0]                 pmem_wdata,
    input  logic                         pmem_resp,
    input  logic [11:0]                  lookup_address,
    output logic                         lookup_hit,
    output logic [127:0]                 lookup_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]          valid_q;
    lc3b_line_addr [DEPTH-1:0] addr_q;
    lc3b_line                  data_q [DEPTH];
    logic [PW-1:0]             head_q;
    logic [PW-1:0]             tail_q;
    logic [CW-1:0]             count_q;
    wb_state_t                 state_q;

    logic                      full;
    logic [DEPTH-1:0]          head_mask;
    logic [DEPTH-1:0]          coal_vec;
    logic [PW-1:0]             coal_idx;
    logic                      coal_hit;
    logic [DEPTH-1:0]          look_vec;
    logic [PW-1:0]             look_idx;
    logic                      push;
    logic                      do_coal;
    logic                      do_app;
    logic                      pop;

    assign full     = (count_q == CW'(DEPTH));
    assign wb_ready = !full;
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // The in-flight head is never a coalesce target: its data is already on the bus.
    always_comb begin
        head_mask = '0;
        if (state_q == WB_WRITE) begin
            head_mask[head_q] = 1'b1;
        end
    end

    wb_match #(.DEPTH(DEPTH), .PW(PW)) u_coal_match (
        .addr       (wb_address),
        .entry_addr (addr_q),
        .valid      (valid_q & ~head_mask),
        .tail       (tail_q),
        .hit_vec    (coal_vec),
        .idx        (coal_idx)
    );

    wb_match #(.DEPTH(DEPTH), .PW(PW)) u_lookup_match (
        .addr       (lookup_address),
        .entry_addr (addr_q),
        .valid      (valid_q),
        .tail       (tail_q),
        .hit_vec    (look_vec),
        .idx        (look_idx)
    );

    assign coal_hit    = |coal_vec;
    assign lookup_hit  = |look_vec;
    assign lookup_data = lookup_hit ? data_q[look_idx] : '0;

    assign push    = wb_valid && !full;
    assign do_coal = push && coal_hit;
    assign do_app  = push && !coal_hit;
    assign pop     = (state_q == WB_WRITE) && pmem_resp;

    always_ff @(posedge clk) begin
        if (do_coal) begin
            data_q[coal_idx] <= wb_data;
        end
        if (do_app) begin
            data_q[tail_q] <= wb_data;
            addr_q[tail_q] <= wb_address;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= WB_IDLE;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            if (do_app) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(do_app) - CW'(pop);

            case (state_q)
                WB_IDLE: begin
                    if (!empty) begin
                        state_q      <= WB_WRITE;
                        pmem_write   <= 1'b1;
                        pmem_address <= {addr_q[head_q], 4'b0000};
                        // A coalesce into the head on this same edge must reach the bus.
                        pmem_wdata   <= (do_coal && (coal_idx == head_q)) ? wb_data
                                                                          : data_q[head_q];
                    end
                end
                WB_WRITE: begin
                    if (pmem_resp) begin
                        state_q    <= WB_IDLE;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= WB_IDLE;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vc_writeback_buffer.md
# vc_writeback_buffer

Write-back buffer downstream of the victim-cache datapath. It captures dirty lines evicted from the victim cache (12-bit line address plus 128-bit line), queues them in FIFO order, and drains them to physical memory over the pmem write handshake. It also exposes an associative lookup so the L2 miss path can forward a line that is still queued instead of reading stale memory.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- wb_valid  in  1  an evicted dirty line is presented this cycle.
- wb_address  in  12  line address of the evicted line (byte address [15:4]).
- wb_data  in  128  evicted line contents.
- wb_ready  out  1  buffer can accept a line; equals !full.
- pmem_write  out  1  write request to physical memory.
- pmem_address  out  16  {head address, 4'b0000}.
- pmem_wdata  out  128  head entry data.
- pmem_resp  in  1  memory write complete.
- lookup_address  in  12  L2 miss line address to probe.
- lookup_hit  out  1  a queued entry matches lookup_address.
- lookup_data  out  128  data of the youngest matching entry; 0 when no hit.
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage: DEPTH entries of {valid, addr[11:0], data[127:0]}, head and tail pointers of width $clog2(DEPTH), which wrap modulo DEPTH.
- Push: accepted when wb_valid & wb_ready.
  - Coalesce: if wb_address matches a valid entry that is not the in-flight head, overwrite that entry's data in place; count unchanged.
  - Otherwise write at tail, set valid, tail+1, count+1.
  - A match against the in-flight head (state WRITE) does not coalesce; the line is appended as a new entry.
- Drain FSM:
  - IDLE: pmem_write=0. If !empty, go to WRITE.
  - WRITE: pmem_write=1; pmem_address/pmem_wdata driven from head and held stable. On pmem_resp, clear head valid, head+1, count−1, go to IDLE.
  - pmem_resp in IDLE is ignored.
- Simultaneous push and pop: both take effect; count is unchanged for an append and decrements for a coalesce.
- Full: wb_ready=0 even if a pop occurs in the same cycle. The upstream stage must hold wb_valid and its data until it sees wb_ready.
- Lookup: purely combinational over stored valid entries only; a same-cycle push is not visible.
  - When several entries match (in-flight head plus a newer append), the entry nearest the tail wins.
- Reset: all valid bits cleared; head=tail=0; count=0; state IDLE; pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Reset asserted during WRITE abandons the in-flight write. A pmem_resp that arrives after reset is ignored.

## Timing
- Push visible to lookup, count and empty on the cycle after acceptance.
- Earliest pmem_write is 2 cycles after a push into an empty buffer (capture edge, then IDLE→WRITE edge).
- pmem_write deasserts on the edge after pmem_resp. There is at least one IDLE cycle between consecutive writes.
- Throughput: one line per (memory latency + 2) cycles.
- lookup_hit/lookup_data are same-cycle combinational from lookup_address and registered state.
- wb_ready, empty, count come directly from registered state and have no combinational path from inputs.

## Structure
- lc3b_types (shared package) gains:
  - lc3b_line (logic [127:0]).
  - lc3b_line_addr (logic [11:0]).
  - wb_state_t enum {WB_IDLE, WB_WRITE}.
- Sub-module wb_match: parallel 12-bit compare of one address against all entries, qualified by valid. Returns a hit vector plus a youngest-first priority select (relative to tail) producing the index.
  - Instantiated twice: once for coalesce, with the in-flight head masked; once for lookup.
- Top level holds the storage array, pointers, count and FSM.

## Test plan
- Reset during traffic: fill 2 entries, hold reset_n=0 for 1 cycle while pmem_write=1 → next cycle empty=1, count=0, pmem_write=0; a later pmem_resp causes no pop.
- Single drain: push addr 12'h0A5, data 128'hDEAD…BEEF into empty buffer → pmem_write=1 two cycles later with pmem_address=16'h0A50 and matching data; after 3-cycle resp delay, empty=1.
- Fill and backpressure: push 4 distinct lines with pmem_resp=0 → wb_ready=0, count=4, and a 5th push is held. One pmem_resp → wb_ready=1 next cycle, and the held line is appended at the wrapped tail.
- Coalesce: with head 12'h010 in WRITE, push 12'h020 data A then 12'h020 data B → count=2, the second write issued carries B. Separately, push 12'h010 → count=3 (appended, not coalesced).
- Lookup priority: in-flight head 12'h010 data X plus appended 12'h010 data Y → lookup 12'h010 gives hit=1, data=Y. Lookup 12'h7FF gives hit=0, data=0.
- Simultaneous push/pop at count=2: pmem_resp and an append in the same cycle → count stays 2, and FIFO order is preserved across the pointer wrap.
